load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving the memory word-address width (4*2^ADDR_W bytes addressable).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  access request present.
REQ-005 SHALL have port req_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  access rejected, qualified by resp_valid.
REQ-013 SHALL have ports mem_read and mem_write  output  1 each  word-memory read and write enables.
REQ-014 SHALL have port mem_addr  output  ADDR_W  word address (req_addr[ADDR_W+1:2]).
REQ-015 SHALL have ports mem_wdata  output  32, and mem_rdata  input  32; memory read is combinational and the write commits on the clk edge while mem_write=1.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL latch the request on the edge where req_valid&&req_ready; IDLE then moves to RESP on error, to READ on a load or B/H store, and to WRITE on a W store.
REQ-018 In READ, SHALL assert mem_read and capture mem_rdata on the closing edge; a load then goes to RESP and a sub-word store goes to WRITE.
REQ-019 In WRITE, SHALL assert mem_write for exactly one cycle with mem_wdata = the full store word, or the captured word with only the addressed byte/halfword replaced; then go to RESP.
REQ-020 In RESP, SHALL assert resp_valid for one cycle and then return to IDLE; response latency after the accept edge SHALL be 2 cycles for loads and W stores, 3 for B/H stores, and 1 for errors.
REQ-021 Loads SHALL select the byte by addr[1:0] and the halfword by addr[1]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, W SHALL pass through.
REQ-022 mem_read and mem_write SHALL never be high together and SHALL be 0 in IDLE and RESP; mem_wdata SHALL be 0 outside WRITE.
REQ-023 Invalid funct3 (011, 110, 111), and stores coded BU/HU, SHALL produce resp_err=1 with no memory access.

Reset
REQ-024 rst low SHALL force IDLE asynchronously: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, and captured data cleared.
REQ-025 Reset asserted mid-access SHALL abort the access: mem_write drops immediately, no response is issued, and the first request after release is accepted normally.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined, a misaligned H/HU (addr[0]=1) or W (addr[1:0]!=0) access, or any address with a nonzero req_addr[31:ADDR_W+2], SHALL produce resp_err=1 with no memory access.
REQ-027 Without LSU_MISALIGN_TRAP_EN, alignment and range SHALL not be checked: H forces addr[0]=0, W forces addr[1:0]=0, upper bits are ignored, and resp_err reports only REQ-023 errors.

Structure
REQ-028 Package lsu_pkg SHALL hold the funct3 constants, the FSM state enum, and the default ADDR_W.
REQ-029 Byte-lane extract/extend and store merge SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-030 With word1=0x00000009, LW 0x4 -> one mem_read cycle at mem_addr=1, then resp_valid 2 cycles after accept with rdata=0x00000009 and err=0.
REQ-031 With word0=0x80FF1234, LB 0x3 -> 0xFFFFFF80; LBU 0x3 -> 0x00000080; LH 0x2 -> 0xFFFF80FF.
REQ-032 With word1=0x11223344, SB 0x5 wdata=0x000000AB -> one READ cycle, then one WRITE of 0x1122AB44 to mem_addr=1, then resp at 3 cycles.
REQ-033 LH 0x1 with the macro -> resp_err=1 at 1 cycle and no mem_read/mem_write; without the macro -> reads mem_addr=0 with err=0.
REQ-034 LW 0x100 with ADDR_W=6 and the macro -> resp_err=1 and no memory access.
REQ-035 SW 0x8 with rst pulled low during WRITE -> mem_write drops the same cycle, no resp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 width codes, FSM states, default sizing.
package lsu_pkg;

  localparam int DEFAULT_ADDR_W = 6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Unsigned variants only make sense for loads, so a store coded BU/HU is rejected.
  function automatic logic funct3_illegal(input logic [2:0] funct3, input logic write);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_illegal = 1'b0;
      F3_BU, F3_HU:     funct3_illegal = write;
      default:          funct3_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store data into a memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (byte_off)
      2'd0:    sel_byte = load_word[7:0];
      2'd1:    sel_byte = load_word[15:8];
      2'd2:    sel_byte = load_word[23:16];
      default: sel_byte = load_word[31:24];
    endcase
    sel_half = byte_off[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'd0, sel_half};
      F3_W:    load_data = load_word;
      default: load_data = 32'd0;
    endcase
  end

  // Read-modify-write: only the addressed lane takes new data, the rest keeps the captured word.
  always_comb begin
    merge_data = load_word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    merge_data[7:0]   = store_data[7:0];
          2'd1:    merge_data[15:8]  = store_data[7:0];
          2'd2:    merge_data[23:16] = store_data[7:0];
          default: merge_data[31:24] = store_data[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off[1]) merge_data[31:16] = store_data[15:0];
        else             merge_data[15:0]  = store_data[15:0];
      end
      F3_W:    merge_data = store_data;
      default: merge_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide memory; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned and out-of-range addresses instead of masking them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_next;
  logic              q_write, q_err;
  logic [2:0]        q_funct3;
  logic [ADDR_W-1:0] q_addr;
  logic [1:0]        q_off;
  logic [31:0]       q_wdata, q_rdata;
  logic              accept, req_err;
  logic [1:0]        eff_off;
  logic [31:0]       load_data, merge_data;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign, out_of_range;

  always_comb begin
    case (req_funct3)
      F3_H, F3_HU: misalign = req_addr[0];
      F3_W:        misalign = |req_addr[1:0];
      default:     misalign = 1'b0;
    endcase
  end

  assign out_of_range = |(req_addr >> (ADDR_W + 2));
  assign req_err = funct3_illegal(req_funct3, req_write) || misalign || out_of_range;
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[31:ADDR_W+2];
  assign req_err = funct3_illegal(req_funct3, req_write);
`endif

  // Halfword and word accesses ignore the low address bits they cannot use.
  always_comb begin
    case (req_funct3)
      F3_H, F3_HU: eff_off = {req_addr[1], 1'b0};
      F3_W:        eff_off = 2'b00;
      default:     eff_off = req_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_write  <= 1'b0;
      q_err    <= 1'b0;
      q_funct3 <= 3'd0;
      q_addr   <= '0;
      q_off    <= 2'd0;
      q_wdata  <= 32'd0;
      q_rdata  <= 32'd0;
    end else begin
      if (accept) begin
        q_write  <= req_write;
        q_err    <= req_err;
        q_funct3 <= req_funct3;
        q_addr   <= req_addr[ADDR_W+1:2];
        q_off    <= eff_off;
        q_wdata  <= req_wdata;
      end
      if (state == READ) begin
        q_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                              state_next = RESP;
          else if (req_write && req_funct3 == F3_W) state_next = WRITE;
          else                                      state_next = READ;
        end
      end
      READ:    state_next = q_write ? WRITE : RESP;
      WRITE:   state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    case (state)
      IDLE: req_ready = 1'b1;
      READ: begin
        mem_read = 1'b1;
        mem_addr = q_addr;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = q_addr;
        mem_wdata = merge_data;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = q_err;
        resp_rdata = (q_err || q_write) ? 32'd0 : load_data;
      end
    endcase
  end

  lsu_align u_align (
    .funct3     (q_funct3),
    .byte_off   (q_off),
    .load_word  (q_rdata),
    .store_data (q_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  logic [31:0] mem [2**ADDR_W];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one request, then watches the memory port and response against the scoreboard.
  task automatic apply_stimulus(input string tag, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input int exp_reads, input int exp_writes,
                                input logic [ADDR_W-1:0] exp_maddr, input logic [31:0] exp_mwdata);
    exp_t e, got;
    int reads, writes, both;
    bit seen;
    logic [ADDR_W-1:0] seen_maddr;
    logic [31:0] seen_mwdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reads = 0; writes = 0; both = 0; seen = 1'b0;
    seen_maddr = '0; seen_mwdata = 32'd0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (mem_read) begin reads++; seen_maddr = mem_addr; end
      if (mem_write) begin writes++; seen_maddr = mem_addr; seen_mwdata = mem_wdata; end
      if (mem_read && mem_write) both++;
      if (resp_valid) begin
        seen = 1'b1;
        got = sb.pop_front();
        check_output({tag, "_rdata"}, resp_rdata, got.rdata);
        check_output({tag, "_err"}, 32'(resp_err), 32'(got.err));
        check_output({tag, "_latency"}, 32'(k), 32'(got.lat));
      end
    end
    if (!seen) begin
      void'(sb.pop_front());
      check_output({tag, "_resp_timeout"}, 32'd0, 32'd1);
    end
    check_output({tag, "_reads"}, 32'(reads), 32'(exp_reads));
    check_output({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    check_output({tag, "_rw_overlap"}, 32'(both), 32'd0);
    if (exp_reads + exp_writes > 0)
      check_output({tag, "_mem_addr"}, 32'(seen_maddr), 32'(exp_maddr));
    if (exp_writes > 0)
      check_output({tag, "_mem_wdata"}, seen_mwdata, exp_mwdata);
    @(negedge clk);
    check_output({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    bit stray_resp;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'd0;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check_output("rst_ready", 32'(req_ready), 32'd1);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_resp_err", 32'(resp_err), 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'd0);
    check_output("rst_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    mem[0] = 32'h80FF1234;
    mem[1] = 32'h00000009;
    apply_stimulus("lw_4",   1'b0, F3_W,  32'h4, 32'h0, 32'h00000009, 1'b0, 2, 1, 0, 6'd1, 32'h0);
    apply_stimulus("lb_3",   1'b0, F3_B,  32'h3, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 6'd0, 32'h0);
    apply_stimulus("lbu_3",  1'b0, F3_BU, 32'h3, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 6'd0, 32'h0);
    apply_stimulus("lh_2",   1'b0, F3_H,  32'h2, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 6'd0, 32'h0);
    apply_stimulus("lhu_2",  1'b0, F3_HU, 32'h2, 32'h0, 32'h000080FF, 1'b0, 2, 1, 0, 6'd0, 32'h0);
    apply_stimulus("lb_1",   1'b0, F3_B,  32'h1, 32'h0, 32'h00000012, 1'b0, 2, 1, 0, 6'd0, 32'h0);

    mem[1] = 32'h11223344;
    apply_stimulus("sb_5",   1'b1, F3_B,  32'h5, 32'h000000AB, 32'h0, 1'b0, 3, 1, 1, 6'd1, 32'h1122AB44);
    check_output("sb_5_mem", mem[1], 32'h1122AB44);
    apply_stimulus("sh_6",   1'b1, F3_H,  32'h6, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1, 6'd1, 32'hBEEFAB44);
    check_output("sh_6_mem", mem[1], 32'hBEEFAB44);
    apply_stimulus("sw_8",   1'b1, F3_W,  32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 6'd2, 32'hDEADBEEF);
    apply_stimulus("lw_8",   1'b0, F3_W,  32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 6'd2, 32'h0);

    apply_stimulus("bad_f3", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0, 6'd0, 32'h0);
    apply_stimulus("sbu",    1'b1, F3_BU, 32'h4, 32'h55, 32'h0, 1'b1, 1, 0, 0, 6'd0, 32'h0);
    check_output("sbu_mem", mem[1], 32'hBEEFAB44);

`ifdef LSU_MISALIGN_TRAP_EN
    apply_stimulus("lh_1",   1'b0, F3_H,  32'h1, 32'h0, 32'h0, 1'b1, 1, 0, 0, 6'd0, 32'h0);
    apply_stimulus("lw_100", 1'b0, F3_W,  32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0, 6'd0, 32'h0);
`else
    apply_stimulus("lh_1",   1'b0, F3_H,  32'h1, 32'h0, 32'h00001234, 1'b0, 2, 1, 0, 6'd0, 32'h0);
    apply_stimulus("lw_100", 1'b0, F3_W,  32'h100, 32'h0, 32'h80FF1234, 1'b0, 2, 1, 0, 6'd0, 32'h0);
`endif

    // Abort a word store by pulling reset while it is in WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h8; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("abort_write_active", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check_output("abort_write_drop", 32'(mem_write), 32'd0);
    check_output("abort_ready", 32'(req_ready), 32'd1);
    check_output("abort_mem_wdata", mem_wdata, 32'd0);
    stray_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) stray_resp = 1'b1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) stray_resp = 1'b1;
    end
    check_output("abort_no_resp", 32'(stray_resp), 32'd0);
    check_output("abort_mem_kept", mem[2], 32'hDEADBEEF);
    apply_stimulus("post_rst_lw", 1'b0, F3_W, 32'h4, 32'h0, 32'hBEEFAB44, 1'b0, 2, 1, 0, 6'd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
